// File: rtl/ebpf_operand_extend_pipe_if.sv
// Operand-normaliser handshake bundle: input beat (operand, size code, flags, tag) and result beat.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready close each valid-ready leg; master = producer/consumer side, slave = pipe.
interface ebpf_operand_extend_pipe_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_size;
    logic              in_signed;
    logic              in_bswap;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_size, in_signed, in_bswap, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_size, in_signed, in_bswap, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/ebpf_operand_extend_pipe.sv
// Operand normaliser: select 8/16/32/64-bit field, optional END-style byte swap, then sign/zero extend to DATA_W.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle sustained.
// Backpressure: stages advance only into a free or draining slot; in_ready = stage-1 can advance (forced 1 in reset).
// Ports: clk, rst (sync, active-high), flush (sync clear of valids, data held),
//        io (slave): in_valid/in_ready/in_data/in_size/in_signed/in_bswap/in_tag -> out_valid/out_ready/out_data/out_tag.
module ebpf_operand_extend_pipe #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    ebpf_operand_extend_pipe_if.slave    io
);

    // Stage-1 payload: field already masked to its size and swapped, upper bits zero.
    typedef struct packed {
        logic [63:0]      val;
        logic             sgn;
        logic [1:0]       size;
        logic [TAG_W-1:0] tag;
    } s1_t;

    s1_t               s1_q;
    s1_t               s1_d;
    logic              s1_valid;
    logic              s2_valid;
    logic              s1_adv;
    logic              s2_adv;
    logic [63:0]       raw;
    logic              msb;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] ext_d;
    logic [DATA_W-1:0] out_data_q;
    logic [TAG_W-1:0]  out_tag_q;

    assign s2_adv       = !s2_valid || io.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    // Reset overrides so upstream never sees a stall while the pipe is being cleared.
    assign io.in_ready  = rst || s1_adv;
    assign io.out_valid = s2_valid;
    assign io.out_data  = out_data_q;
    assign io.out_tag   = out_tag_q;

    // Only the low 64 bits can ever be selected; anything above is ignored.
    assign raw = io.in_data[63:0];

    // Stage 1: pick the field, swap bytes within it. An 8-bit field has nothing to swap.
    always_comb begin
        s1_d      = '0;
        s1_d.sgn  = io.in_signed;
        s1_d.size = io.in_size;
        s1_d.tag  = io.in_tag;
        case (io.in_size)
            2'd0: s1_d.val[7:0]  = raw[7:0];
            2'd1: s1_d.val[15:0] = io.in_bswap ? {raw[7:0], raw[15:8]} : raw[15:0];
            2'd2: s1_d.val[31:0] = io.in_bswap ?
                                   {raw[7:0], raw[15:8], raw[23:16], raw[31:24]} : raw[31:0];
            default: s1_d.val    = io.in_bswap ?
                                   {raw[7:0],   raw[15:8],  raw[23:16], raw[31:24],
                                    raw[39:32], raw[47:40], raw[55:48], raw[63:56]} : raw;
        endcase
    end

    // Stage 2: fill everything above the field with the post-swap MSB (signed) or zero.
    always_comb begin
        keep = '0;
        msb  = 1'b0;
        case (s1_q.size)
            2'd0: begin keep[7:0]  = '1; msb = s1_q.val[7];  end
            2'd1: begin keep[15:0] = '1; msb = s1_q.val[15]; end
            2'd2: begin keep[31:0] = '1; msb = s1_q.val[31]; end
            default: begin keep[63:0] = '1; msb = s1_q.val[63]; end
        endcase
        ext_d = DATA_W'(s1_q.val) | ({DATA_W{s1_q.sgn & msb}} & ~keep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_q       <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (flush) begin
            // Drop everything in flight and the beat offered this cycle; payload regs keep old contents.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= ext_d;
                    out_tag_q  <= s1_q.tag;
                end
            end
            if (s1_adv) begin
                s1_valid <= io.in_valid;
                if (io.in_valid) begin
                    s1_q <= s1_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_ebpf_operand_extend_pipe.sv
module tb_ebpf_operand_extend_pipe;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    exp_t        exp_q[$];
    logic [3:0]  got_tags[$];
    int          got_cyc[$];

    ebpf_operand_extend_pipe_if #(.DATA_W(64), .TAG_W(4)) ifc ();

    ebpf_operand_extend_pipe #(.DATA_W(64), .TAG_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: byte-wise select/reverse, then fill above the field from its top bit.
    function automatic logic [63:0] model(input logic [63:0] d, input logic [1:0] sz,
                                          input logic sg, input logic bs);
        int nb;
        logic [63:0] v;
        logic [63:0] r;
        nb = 1 << sz;
        v  = '0;
        for (int i = 0; i < nb; i++)
            v[8*i +: 8] = bs ? d[8*(nb-1-i) +: 8] : d[8*i +: 8];
        r = v;
        if (sg && v[8*nb-1])
            for (int i = 8*nb; i < 64; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Scoreboard: push on accept, pop/compare on each output handshake; flush/rst drop in-flight entries.
    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_unexpected got tag=%0d data=%h with nothing expected",
                             ifc.out_tag, ifc.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ifc.out_data !== e.data || ifc.out_tag !== e.tag) begin
                        failures++;
                        $display("FAIL scoreboard_beat got tag=%0d data=%h expected tag=%0d data=%h",
                                 ifc.out_tag, ifc.out_data, e.tag, e.data);
                    end
                end
                got_tags.push_back(ifc.out_tag);
                got_cyc.push_back(cyc);
            end
            if (rst || flush) begin
                exp_q.delete();
            end else if (ifc.in_valid === 1'b1 && ifc.in_ready === 1'b1) begin
                e.data = model(ifc.in_data, ifc.in_size, ifc.in_signed, ifc.in_bswap);
                e.tag  = ifc.in_tag;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [1:0] sz, input logic sg,
                             input logic bs, input logic [3:0] tag);
        int t = 0;
        @(posedge clk); #1;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = d;
        ifc.in_size   = sz;
        ifc.in_signed = sg;
        ifc.in_bswap  = bs;
        ifc.in_tag    = tag;
        @(negedge clk);
        while (ifc.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_beat_timeout in_ready=%b required 1 within 50 cycles", ifc.in_ready);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifc.out_valid !== 1'b1 && n < 20);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got %b required 1", ifc.in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 64'h0 || ifc.out_tag !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h tag=%0d required 0/0/0",
                     ifc.out_valid, ifc.out_data, ifc.out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got out_valid=%b in_ready=%b required 0/1",
                     ifc.out_valid, ifc.in_ready);
        end
    endtask

    task automatic test_sign_extend16();
        int n;
        ifc.out_ready = 1'b1;
        send_beat(64'h0000_0000_0000_8001, 2'b01, 1'b1, 1'b0, 4'h5);
        wait_out(n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL sext16_latency got %0d required 2", n); end
        checks++;
        if (ifc.out_data !== 64'hFFFF_FFFF_FFFF_8001) begin
            failures++; $display("FAIL sext16_data got %h required ffffffffffff8001", ifc.out_data);
        end
        checks++;
        if (ifc.out_tag !== 4'h5) begin
            failures++; $display("FAIL sext16_tag got %0d required 5", ifc.out_tag);
        end
    endtask

    task automatic test_zero_extend8();
        int n;
        send_beat(64'hDEAD_BEEF_1234_FF80, 2'b00, 1'b0, 1'b0, 4'h2);
        wait_out(n);
        checks++;
        if (ifc.out_data !== 64'h0000_0000_0000_0080) begin
            failures++; $display("FAIL zext8_data got %h required 0000000000000080", ifc.out_data);
        end
        send_beat(64'hDEAD_BEEF_1234_FF80, 2'b00, 1'b1, 1'b0, 4'h3);
        wait_out(n);
        checks++;
        if (ifc.out_data !== 64'hFFFF_FFFF_FFFF_FF80 || ifc.out_tag !== 4'h3) begin
            failures++;
            $display("FAIL sext8_data got data=%h tag=%0d required ffffffffffffff80 tag=3",
                     ifc.out_data, ifc.out_tag);
        end
    endtask

    task automatic test_bswap();
        int n;
        send_beat(64'hABCD_0000_9999_1234, 2'b01, 1'b0, 1'b1, 4'h7);
        wait_out(n);
        checks++;
        if (ifc.out_data !== 64'h0000_0000_0000_3412) begin
            failures++; $display("FAIL bswap16 got %h required 0000000000003412", ifc.out_data);
        end
        send_beat(64'h0000_0000_0000_0080, 2'b10, 1'b1, 1'b1, 4'h8);
        wait_out(n);
        checks++;
        if (ifc.out_data !== 64'hFFFF_FFFF_8000_0000) begin
            failures++; $display("FAIL bswap32_sext got %h required ffffffff80000000", ifc.out_data);
        end
        send_beat(64'h0102_0304_0506_0708, 2'b11, 1'b0, 1'b1, 4'h9);
        wait_out(n);
        checks++;
        if (ifc.out_data !== 64'h0807_0605_0403_0201) begin
            failures++; $display("FAIL bswap64 got %h required 0807060504030201", ifc.out_data);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int ci   = 0;
        int t    = 0;
        logic [63:0] held = '0;
        @(negedge clk);
        got_tags.delete();
        got_cyc.delete();
        ifc.out_ready = 1'b0;
        @(posedge clk); #1;
        while (sent < 5 && ci < 100) begin
            ifc.in_valid  = 1'b1;
            ifc.in_data   = 64'hDEAD_0000_0000_0000 | 64'(sent * 37);
            ifc.in_size   = 2'(sent);
            ifc.in_signed = (sent % 2) == 1;
            ifc.in_bswap  = sent > 1;
            ifc.in_tag    = 4'(sent);
            @(negedge clk);
            if (ci == 2) begin
                held = ifc.out_data;
                checks++;
                if (held !== model(64'hDEAD_0000_0000_0000, 2'd0, 1'b0, 1'b0) || ifc.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_first_beat got valid=%b data=%h required 1/0000000000000000",
                             ifc.out_valid, held);
                end
            end
            if (ci == 2 || ci == 3) begin
                checks++;
                if (ifc.in_ready !== 1'b0 || sent != 2) begin
                    failures++;
                    $display("FAIL bp_full got in_ready=%b accepted=%0d required 0/2", ifc.in_ready, sent);
                end
            end
            if (ci == 3) begin
                checks++;
                if (ifc.out_data !== held || ifc.out_tag !== 4'd0 || ifc.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold got data=%h tag=%0d required %h tag=0", ifc.out_data, ifc.out_tag, held);
                end
            end
            if (ifc.in_ready === 1'b1) sent++;
            @(posedge clk); #1;
            ci++;
            if (ci >= 4) ifc.out_ready = 1'b1;
        end
        ifc.in_valid = 1'b0;
        while (got_tags.size() < 5 && t < 30) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got_tags.size() || got_tags[i] !== 4'(i)) begin
                failures++;
                $display("FAIL bp_order index %0d got %0d beats required tag %0d", i, got_tags.size(), i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i + 1 >= got_cyc.size() || got_cyc[i+1] - got_cyc[i] != 1) begin
                failures++;
                $display("FAIL bp_back_to_back gap after beat %0d not 1 cycle (beats seen %0d)", i, got_cyc.size());
            end
        end
    endtask

    task automatic test_flush();
        int n;
        @(negedge clk);
        got_tags.delete();
        ifc.out_ready = 1'b0;
        @(posedge clk); #1;
        ifc.in_valid = 1'b1; ifc.in_data = 64'h11; ifc.in_size = 2'd0;
        ifc.in_signed = 1'b0; ifc.in_bswap = 1'b0; ifc.in_tag = 4'd8;
        @(posedge clk); #1;
        ifc.in_tag = 4'd9;
        @(posedge clk); #1;
        flush = 1'b1; ifc.in_tag = 4'd10;
        @(negedge clk);
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_prefill got out_valid=%b in_ready=%b required 1/0", ifc.out_valid, ifc.in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; ifc.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_clear got out_valid=%b required 0", ifc.out_valid);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1; ifc.in_valid = 1'b1; ifc.in_tag = 4'd11;
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_drop_ready got in_ready=%b required 1", ifc.in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; ifc.in_tag = 4'd12; ifc.in_data = 64'h00FF;
        ifc.in_size = 2'd1; ifc.in_signed = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        wait_out(n);
        checks++;
        if (n != 2 || ifc.out_tag !== 4'd12 || ifc.out_data !== 64'h0000_0000_0000_00FF) begin
            failures++;
            $display("FAIL flush_resume got latency=%0d tag=%0d data=%h required 2/12/00000000000000ff",
                     n, ifc.out_tag, ifc.out_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got_tags.size() != 1 || got_tags[0] !== 4'd12) begin
            failures++;
            $display("FAIL flush_no_ghost got %0d beats first tag=%0d required exactly tag 12",
                     got_tags.size(), got_tags.size() > 0 ? got_tags[0] : 4'd0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        got_tags.delete();
        ifc.out_ready = 1'b0;
        send_beat(64'h7F, 2'd0, 1'b1, 1'b0, 4'd1);
        send_beat(64'h80, 2'd0, 1'b1, 1'b0, 4'd2);
        @(posedge clk); #1;
        ifc.in_valid = 1'b1; ifc.in_tag = 4'd3;
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            failures++; $display("FAIL rstmid_full got in_ready=%b required 0", ifc.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_in_ready_during got %b required 1", ifc.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; ifc.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 64'h0 || ifc.out_tag !== 4'h0 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after got valid=%b data=%h tag=%0d in_ready=%b required 0/0/0/1",
                     ifc.out_valid, ifc.out_data, ifc.out_tag, ifc.in_ready);
        end
        ifc.out_ready = 1'b1;
        send_beat(64'h8000_0000, 2'b10, 1'b1, 1'b0, 4'd6);
        wait_out(n);
        checks++;
        if (n != 2 || ifc.out_data !== 64'hFFFF_FFFF_8000_0000) begin
            failures++;
            $display("FAIL rstmid_resume got latency=%0d data=%h required 2/ffffffff80000000", n, ifc.out_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got_tags.size() != 1 || got_tags[0] !== 4'd6) begin
            failures++;
            $display("FAIL rstmid_lost_beats got %0d beats required only tag 6", got_tags.size());
        end
    endtask

    task automatic test_random_stream();
        int mine = 0;
        int t    = 0;
        @(negedge clk);
        got_tags.delete();
        @(posedge clk); #1;
        while (mine < 40 && t < 2000) begin
            ifc.in_valid  = $urandom_range(0, 3) != 0;
            ifc.in_data   = {$urandom, $urandom};
            ifc.in_size   = 2'($urandom_range(0, 3));
            ifc.in_signed = 1'($urandom_range(0, 1));
            ifc.in_bswap  = 1'($urandom_range(0, 1));
            ifc.in_tag    = 4'($urandom_range(0, 15));
            ifc.out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (ifc.in_valid === 1'b1 && ifc.in_ready === 1'b1) mine++;
            @(posedge clk); #1;
            t++;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (got_tags.size() != 40 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_count got %0d beats out, %0d pending required 40 out, 0 pending",
                     got_tags.size(), exp_q.size());
        end
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_size   = '0;
        ifc.in_signed = 1'b0;
        ifc.in_bswap  = 1'b0;
        ifc.in_tag    = '0;
        ifc.out_ready = 1'b0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_sign_extend16();
        test_zero_extend8();
        test_bswap();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
